axi_lite_master_interface: RTL
==============================

// Module: axi_lite_master_interface
// PURPOSE
// - AXI-Lite master front end, directly upstream of axi_lite_slave_interface.
// - Turns a simple one-shot request/response port into a full AXI-Lite write (AW+W then B)
//   or read (AR then R) transaction, then returns data and response to the requester.
// - Holds one transaction in flight. A timeout recovers from a slave that never answers.
// PARAMETERS
// ADDR_WIDTH       32  address width
// DATA_WIDTH       32  data width
// TRANS_W_STRB_W   4   write strobe width (DATA_WIDTH/8)
// TRANS_WR_RESP_W  2   bresp/rresp width
// TRANS_PROT       3   awprot/arprot width
// TIMEOUT_CYCLES   64  cycles from request accept to forced completion; 0 disables the timeout
// PORTS
// clk_i           in   1               clock, all logic on posedge
// resetn_i        in   1               asynchronous active-low reset
// i_req_valid     in   1               request present
// o_req_ready     out  1               request accepted when valid&&ready
// i_req_write     in   1               1=write, 0=read
// i_req_addr      in   ADDR_WIDTH      transaction address
// i_req_wdata     in   DATA_WIDTH      write data
// i_req_wstrb     in   TRANS_W_STRB_W  write strobes
// i_req_prot      in   TRANS_PROT      protection bits
// o_rsp_valid     out  1               response present
// i_rsp_ready     in   1               response consumed when valid&&ready
// o_rsp_rdata     out  DATA_WIDTH      read data; 0 for writes
// o_rsp_resp      out  TRANS_WR_RESP_W bresp/rresp, or DECERR on timeout
// o_rsp_timeout   out  1               response was produced by the timeout
// o_axi_awaddr/o_axi_awprot/o_axi_awvalid  out, i_axi_awready  in    AW channel
// o_axi_wdata/o_axi_wstrb/o_axi_wvalid     out, i_axi_wready   in    W channel
// i_axi_bresp/i_axi_bvalid                 in,  o_axi_bready   out   B channel
// o_axi_araddr/o_axi_arprot/o_axi_arvalid  out, i_axi_arready  in    AR channel
// i_axi_rdata/i_axi_rresp/i_axi_rvalid     in,  o_axi_rready   out   R channel
// BEHAVIOUR
// - Reset (async, active-low): state=IDLE. Every output is 0, including o_req_ready.
//   o_req_ready rises on the first clock edge after reset is released.
// - FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
// - IDLE: o_req_ready=1. On accept, latch addr/wdata/wstrb/prot/write.
//   The next state is WR_AW_W for a write and RD_AR for a read.
// - Request-to-valid latency: AW/W or AR valid is registered high in the cycle after accept.
// - WR_AW_W: awvalid and wvalid are asserted together.
//   - Each drops independently on its own handshake; aw_done/w_done flags record it.
//   - Both handshakes in the same cycle, or the second of the two -> WR_B.
// - WR_B: o_axi_bready=1 unconditionally; the downstream slave requires ready before valid.
//   - bvalid&&bready: capture bresp, rdata=0 -> RSP.
// - RD_AR: arvalid=1 until arready, then -> RD_R.
// - RD_R: o_axi_rready=1 unconditionally.
//   - rvalid&&rready: capture rdata and rresp -> RSP.
// - RSP: o_rsp_valid=1 with stable data. On i_rsp_ready -> IDLE.
//   - Back-to-back requests cost one extra IDLE cycle; there is no RSP->accept bypass.
// - Payload stability: AXI payloads are driven from the latched request. They stay stable
//   while valid is high and are held (not zeroed) after the handshake.
// - Timeout: a counter clears on accept and increments in every non-IDLE, non-RSP state.
//   - Reaching TIMEOUT_CYCLES forces all AXI valid/ready low and moves to RSP.
//   - The forced response is resp=2'b11 (DECERR), o_rsp_timeout=1, rdata=0.
//   - If the counter hits TIMEOUT_CYCLES in the same cycle as the completing handshake,
//     the handshake wins.
//   - The counter saturates and never wraps. Its width is $clog2(TIMEOUT_CYCLES+1).
// - Dropping a valid on timeout is a deliberate protocol deviation for hang recovery only.
// - A reset mid-transaction aborts immediately. No response is produced.
// - A request arriving while not in IDLE is ignored, because o_req_ready=0.
// STRUCTURE
// - Shared package axi_lite_pkg holds:
//   - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
//   - FSM state localparams (3-bit encoding)
// - One sub-module: axi_lite_timeout_cnt. Inputs clr/en, output expired.
//   It saturates and treats TIMEOUT_CYCLES=0 as never expiring.
// - Everything else stays in a single FSM plus a datapath register block.
// TESTING
// - Basic write: req write addr=0x10 data=0xDEADBEEF strb=0xF; slave readies after 2 cycles,
//   bresp=00 -> AW/W seen with those values, rsp_valid, resp=00, timeout=0.
// - Basic read: req read addr=0x24; slave returns rdata=0x12345678 rresp=00
//   -> rsp rdata=0x12345678, resp=00; bready never asserted.
// - AW/W skew: awready at cycle 1, wready at cycle 5 -> awvalid drops after cycle 1,
//   wvalid held through cycle 5, and exactly one B wait follows.
// - Error pass-through: bresp=2'b10 -> o_rsp_resp=2'b10, o_rsp_timeout=0.
// - Timeout: TIMEOUT_CYCLES=8, slave never asserts arready -> at cycle 8 arvalid=0,
//   rsp resp=2'b11, timeout=1; a following read completes normally.
// - Reset mid-op: assert resetn_i low in WR_B -> all outputs 0 asynchronously;
//   after release, o_req_ready=1 and there is no spurious rsp_valid.
// - Response backpressure: i_rsp_ready held low 10 cycles -> rsp data stable and
//   o_req_ready=0 throughout.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// Saturating transaction timeout counter; TIMEOUT_CYCLES=0 never expires.
module axi_lite_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flags the edge on which the count reaches TIMEOUT_CYCLES, so the FSM leaves on that edge.
    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q == CNT_MAX - 1'b1);

endmodule

// File: rtl/axi_lite_master_interface.sv
// AXI-Lite master front end: one-shot request/response port to a single AXI-Lite
// write (AW+W, B) or read (AR, R) transaction, with timeout-based hang recovery.
module axi_lite_master_interface
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TRANS_W_STRB_W  = 4,
    parameter int unsigned TRANS_WR_RESP_W = 2,
    parameter int unsigned TRANS_PROT      = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [DATA_WIDTH-1:0]      i_req_wdata,
    input  logic [TRANS_W_STRB_W-1:0]  i_req_wstrb,
    input  logic [TRANS_PROT-1:0]      i_req_prot,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [DATA_WIDTH-1:0]      o_rsp_rdata,
    output logic [TRANS_WR_RESP_W-1:0] o_rsp_resp,
    output logic                       o_rsp_timeout,
    output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
    output logic [TRANS_PROT-1:0]      o_axi_awprot,
    output logic                       o_axi_awvalid,
    input  logic                       i_axi_awready,
    output logic [DATA_WIDTH-1:0]      o_axi_wdata,
    output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
    output logic                       o_axi_wvalid,
    input  logic                       i_axi_wready,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
    input  logic                       i_axi_bvalid,
    output logic                       o_axi_bready,
    output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
    output logic [TRANS_PROT-1:0]      o_axi_arprot,
    output logic                       o_axi_arvalid,
    input  logic                       i_axi_arready,
    input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
    input  logic                       i_axi_rvalid,
    output logic                       o_axi_rready
);

    state_e state_q, state_d;

    logic                       req_ready_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [TRANS_W_STRB_W-1:0]  wstrb_q;
    logic [TRANS_PROT-1:0]      prot_q;
    logic                       aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q;
    logic [TRANS_WR_RESP_W-1:0] rsp_resp_q;
    logic                       rsp_timeout_q;

    logic accept, busy, expired, timeout_fire;
    logic aw_hs, w_hs, b_hs, r_hs;

    assign accept = i_req_valid && req_ready_q;
    assign busy   = (state_q == ST_WR_AW_W) || (state_q == ST_WR_B) ||
                    (state_q == ST_RD_AR)   || (state_q == ST_RD_R);

    axi_lite_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clr      (accept),
        .en       (busy),
        .expired  (expired)
    );

    assign o_req_ready   = req_ready_q;
    assign o_axi_awvalid = (state_q == ST_WR_AW_W) && !aw_done_q;
    assign o_axi_wvalid  = (state_q == ST_WR_AW_W) && !w_done_q;
    assign o_axi_bready  = (state_q == ST_WR_B);
    assign o_axi_arvalid = (state_q == ST_RD_AR);
    assign o_axi_rready  = (state_q == ST_RD_R);
    assign o_rsp_valid   = (state_q == ST_RSP);

    assign o_axi_awaddr = addr_q;
    assign o_axi_awprot = prot_q;
    assign o_axi_wdata  = wdata_q;
    assign o_axi_wstrb  = wstrb_q;
    assign o_axi_araddr = addr_q;
    assign o_axi_arprot = prot_q;

    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;

    assign aw_hs = o_axi_awvalid && i_axi_awready;
    assign w_hs  = o_axi_wvalid  && i_axi_wready;
    assign b_hs  = o_axi_bready  && i_axi_bvalid;
    assign r_hs  = o_axi_rready  && i_axi_rvalid;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completing handshakes are tested before expiry so a same-cycle handshake wins.
    always_comb begin
        state_d      = state_q;
        timeout_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = i_req_write ? ST_WR_AW_W : ST_RD_AR;
                end
            end
            ST_WR_AW_W: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WR_B;
                end else if (expired) begin
                    state_d      = ST_RSP;
                    timeout_fire = 1'b1;
                end
            end
            ST_WR_B: begin
                if (b_hs) begin
                    state_d = ST_RSP;
                end else if (expired) begin
                    state_d      = ST_RSP;
                    timeout_fire = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (i_axi_arready) begin
                    state_d = ST_RD_R;
                end else if (expired) begin
                    state_d      = ST_RSP;
                    timeout_fire = 1'b1;
                end
            end
            ST_RD_R: begin
                if (r_hs) begin
                    state_d = ST_RSP;
                end else if (expired) begin
                    state_d      = ST_RSP;
                    timeout_fire = 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            req_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            prot_q        <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                addr_q    <= i_req_addr;
                wdata_q   <= i_req_wdata;
                wstrb_q   <= i_req_wstrb;
                prot_q    <= i_req_prot;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == ST_WR_AW_W) begin
                aw_done_q <= aw_done_q || aw_hs;
                w_done_q  <= w_done_q  || w_hs;
            end
            if (b_hs) begin
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= i_axi_bresp;
                rsp_timeout_q <= 1'b0;
            end
            if (r_hs) begin
                rsp_rdata_q   <= i_axi_rdata;
                rsp_resp_q    <= i_axi_rresp;
                rsp_timeout_q <= 1'b0;
            end
            if (timeout_fire) begin
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= TRANS_WR_RESP_W'(RESP_DECERR);
                rsp_timeout_q <= 1'b1;
            end
        end
    end

endmodule
